// File: rtl/ser_to_par_pkg.sv
// Shared types and constants for the serial-to-parallel converter.
package ser_to_par_pkg;

  localparam int S2P_DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } s2p_state_e;

endpackage : ser_to_par_pkg

// File: rtl/s2p_out_buf.sv
// One-entry output holding register with valid/ready handshake and a sticky
// overrun flag that records completed words dropped while the entry is full.
module s2p_out_buf
  import ser_to_par_pkg::*;
#(
  parameter int WIDTH = S2P_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             dout_ready_i,
  input  logic             ovr_clr_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dout_valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;
  logic             valid_q;
  logic             valid_d;
  logic             ovr_q;
  logic             ovr_d;
  logic             accept_s;

  assign accept_s = valid_q & dout_ready_i;

  // Next-state: an accept frees the entry on the same edge a new word may load.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    if (load_i) begin
      if (!valid_q || accept_s) begin
        dout_d  = load_data_i;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign overrun_o    = ovr_q;

endmodule : s2p_out_buf

// File: rtl/ser_to_par.sv
// Serial-to-parallel converter: MSB-first bits with sof resync are assembled
// into WIDTH-bit words and handed to a one-entry valid/ready output buffer.
module ser_to_par
  import ser_to_par_pkg::*;
#(
  parameter int WIDTH = S2P_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  s2p_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shift_in_s;
  logic [WIDTH-1:0] first_bit_s;
  logic             word_done_s;

  assign shift_in_s  = WIDTH'({shreg_q, din});
  assign first_bit_s = {{(WIDTH-1){1'b0}}, din};

  // A word completes on the WIDTH-th bit; sof restarts so it can never complete.
  assign word_done_s = din_valid & ~sof & (state_q == SHIFT) & (cnt_q == LAST);

  // Bit-assembly FSM: counter, shift register and state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            state_q <= SHIFT;
            cnt_q   <= CW'(1);
            shreg_q <= first_bit_s;
          end
        end
        SHIFT: begin
          if (din_valid) begin
            if (sof) begin
              state_q <= SHIFT;
              cnt_q   <= CW'(1);
              shreg_q <= first_bit_s;
            end else if (cnt_q == LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              shreg_q <= shift_in_s;
            end else begin
              state_q <= SHIFT;
              cnt_q   <= cnt_q + CW'(1);
              shreg_q <= shift_in_s;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          shreg_q <= '0;
        end
      endcase
    end
  end

  s2p_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk          (clk),
    .rst          (rst),
    .load_i       (word_done_s),
    .load_data_i  (shift_in_s),
    .dout_ready_i (dout_ready),
    .ovr_clr_i    (ovr_clr),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .overrun_o    (overrun)
  );

endmodule : ser_to_par

// File: tb/tb_ser_to_par.sv
// Scoreboard bench for ser_to_par: directed scenarios plus random traffic
// compared against a bit-queue reference model.
module tb_ser_to_par;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             sof = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic             overrun;
  logic             ovr_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic          bits_q[$];
  int unsigned   exp_q[$];
  logic          m_full = 1'b0;
  logic          m_ovr  = 1'b0;

  ser_to_par #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model's view of the edge is committed after it.
  task automatic step(input logic v, input logic b, input logic s,
                      input logic r, input logic c);
    logic        done;
    logic        push;
    logic        acc;
    logic        n_full;
    logic        n_ovr;
    int unsigned word;
    din = b; din_valid = v; sof = s; dout_ready = r; ovr_clr = c;
    done = 1'b0; push = 1'b0; word = 0;
    if (v) begin
      if (s) bits_q.delete();
      bits_q.push_back(b);
      if (bits_q.size() == WIDTH) begin
        foreach (bits_q[i]) word = word * 2 + int'(bits_q[i]);
        bits_q.delete();
        done = 1'b1;
      end
    end
    acc    = m_full && r;
    n_full = m_full;
    n_ovr  = c ? 1'b0 : m_ovr;
    if (done) begin
      if (!m_full || acc) begin
        n_full = 1'b1;
        push   = 1'b1;
      end else begin
        n_ovr = 1'b1;
      end
    end else if (acc) begin
      n_full = 1'b0;
    end
    @(posedge clk);
    #1;
    m_full = n_full;
    m_ovr  = n_ovr;
    if (push) exp_q.push_back(word);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  task automatic send_word(input int unsigned w, input int gap, input logic r);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      step(1'b1, w[i], 1'b0, r, 1'b0);
      if (i != 0) idle(gap, r);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_dout_valid", 32'(dout_valid), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    bits_q.delete();
    exp_q.delete();
    m_full = 1'b0;
    m_ovr  = 1'b0;
    din_valid = 1'b0; sof = 1'b0; din = 1'b0; ovr_clr = 1'b0; dout_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Monitor: compare presented word with scoreboard head, retire on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("dout_valid", 32'(dout_valid), 32'(m_full));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (dout_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(dout), 32'hFFFF_FFFF);
          end else begin
            chk("dout", 32'(dout), exp_q[0]);
            if (dout_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    do_reset();

    // 1,0,1,1 back-to-back -> B
    send_word(32'hB, 0, 1'b1);
    idle(3, 1'b1);

    // 0,1,1,0 with two idle cycles between bits -> 6
    send_word(32'h6, 2, 1'b1);
    idle(3, 1'b1);

    // A then 5 with ready low -> 5 dropped, overrun; then accept and clear
    send_word(32'hA, 0, 1'b0);
    send_word(32'h5, 0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // 3 then C with accept coinciding with completion of C
    send_word(32'h3, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // 1,1 partial then sof + 0,1,0,1 -> single word 5; sof without valid ignored
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Reset after two bits, then 1,1,1,0 -> E
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    send_word(32'hE, 0, 1'b1);
    idle(3, 1'b1);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0);
    end
    idle(4, 1'b1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ser_to_par

// File: doc/ser_to_par.md
SER_TO_PAR -- requirements
Module: ser_to_par

Interface
REQ-001 The parameter SHALL be: WIDTH, default 4, the number of serial bits per parallel word (legal range 2..16).
REQ-002 The ports SHALL be: clk  input  1  rising-edge clock for all state.
REQ-003 The ports SHALL be: rst  input  1  asynchronous reset, active-low.
REQ-004 The ports SHALL be: din  input  1  serial data bit, transmitted MSB first.
REQ-005 The ports SHALL be: din_valid  input  1  din is sampled on this edge.
REQ-006 The ports SHALL be: sof  input  1  start of frame; qualified by din_valid, this bit is word bit MSB.
REQ-007 The ports SHALL be: dout  output  WIDTH  assembled parallel word.
REQ-008 The ports SHALL be: dout_valid  output  1  dout holds an unconsumed word.
REQ-009 The ports SHALL be: dout_ready  input  1  consumer accepts dout when high with dout_valid.
REQ-010 The ports SHALL be: overrun  output  1  sticky flag, a completed word was dropped.
REQ-011 The ports SHALL be: ovr_clr  input  1  synchronous clear of overrun.

Function
REQ-012 The block SHALL hold a bit counter (0..WIDTH-1) and a WIDTH-bit shift register; each din_valid cycle shifts din in at the LSB and increments the counter.
REQ-013 Cycles with din_valid low SHALL leave counter and shift register unchanged; arbitrary gaps between bits are legal.
REQ-014 The FSM SHALL have states IDLE (counter 0, no partial word) and SHIFT (1..WIDTH-1 bits held); IDLE->SHIFT on din_valid; SHIFT->IDLE when the WIDTH-th bit is sampled.
REQ-015 A word SHALL complete on the edge where din_valid is high and counter equals WIDTH-1; the counter wraps to 0.
REQ-016 A completed word SHALL appear on dout with dout_valid high on the next cycle (1-cycle latency from last bit sample).
REQ-017 dout and dout_valid SHALL remain stable while dout_valid is high and dout_ready is low.
REQ-018 dout_valid SHALL fall on the edge after dout_valid and dout_ready are both high, unless a new word completes on that same edge.
REQ-019 If a word completes on the same edge that the held word is accepted, the new word SHALL load and dout_valid SHALL stay high (no bubble).
REQ-020 If a word completes while a held word is not accepted on that edge, the new word SHALL be dropped, dout unchanged, and overrun SHALL set.
REQ-021 sof with din_valid SHALL discard any partial word and treat din as the first (MSB) bit; counter becomes 1.
REQ-022 sof without din_valid SHALL be ignored.
REQ-023 ovr_clr SHALL clear overrun on the next edge; a simultaneous new overrun SHALL win (overrun stays 1).
REQ-024 dout_ready while dout_valid is low SHALL have no effect.

Reset
REQ-025 Asserting rst low SHALL immediately force: counter 0, shift register 0, FSM IDLE, dout 0, dout_valid 0, overrun 0.
REQ-026 Reset mid-word SHALL discard the partial word; the first din_valid after release is bit MSB of a new word.
REQ-027 Reset SHALL release synchronously to clk at the integration level; the block needs no internal synchronizer.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration (IDLE, SHIFT) and the default WIDTH constant.
REQ-029 The one-entry output holding register with the valid/ready logic and overrun flag SHALL be a sub-module named s2p_out_buf; counter, shift register and FSM stay in ser_to_par.

Verification
REQ-030 WIDTH=4, ready=1, bits 1,0,1,1 on 4 consecutive cycles -> dout=4'hB, dout_valid high exactly 1 cycle, on the cycle after the 4th bit.
REQ-031 Bits 0,1,1,0 with 2 idle cycles between each -> dout=4'h6 one cycle after the last bit, no earlier valid.
REQ-032 ready=0, words 4'hA then 4'h5 -> dout holds 4'hA, overrun=1; raise ready -> 4'hA accepted, dout_valid drops; pulse ovr_clr -> overrun=0.
REQ-033 Back-to-back words 4'h3, 4'hC with ready=1 and accept coinciding with completion -> dout_valid continuously high across the boundary, values 3 then C.
REQ-034 Two bits 1,1 then sof with bits 0,1,0,1 -> single word 4'h5, partial bits discarded.
REQ-035 Reset asserted after 2 bits, released, then bits 1,1,1,0 -> dout=4'hE; all outputs 0 during reset.
